// File: rtl/vga_image_reader.sv
// VGA 640x480 timing generator that streams a 320x240 12-bit image from BRAM, 2x upscaled.
// Three register stages (address, BRAM, output) keep sync, enable and colour aligned.
module vga_image_reader #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int IMG_W    = 320,
  parameter int IMG_H    = 240
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        video_en,
  output logic [16:0] bram_addr,
  input  logic [11:0] bram_data,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        de,
  output logic        frame_start
);

  localparam int DATA_W = 12;

  typedef logic [9:0] cnt_t;

  localparam cnt_t H_LAST = cnt_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam cnt_t V_LAST = cnt_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam cnt_t H_ACT  = cnt_t'(H_ACTIVE);
  localparam cnt_t V_ACT  = cnt_t'(V_ACTIVE);
  localparam cnt_t H_SS   = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t H_SE   = cnt_t'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam cnt_t V_SS   = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t V_SE   = cnt_t'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam cnt_t V_IMG  = cnt_t'(2 * IMG_H);
  localparam logic [16:0] ROW_STEP = 17'(IMG_W);

  function automatic logic [DATA_W-1:0] gate_pix(input logic [DATA_W-1:0] pix,
                                                 input logic show);
    return show ? pix : '0;
  endfunction

  cnt_t        hcnt;
  cnt_t        vcnt;
  logic [16:0] row_base;
  logic        en_latched;

  logic h_wrap, v_wrap;
  logic vld_p0, hs_p0, vs_p0, fs_p0;
  logic vld_p1, hs_p1, vs_p1, fs_p1;
  logic vld_p2, hs_p2, vs_p2, fs_p2;

  // ---- stage 0: raster counters and decoded timing ----
  assign h_wrap = (hcnt == H_LAST);
  assign v_wrap = (vcnt == V_LAST);
  assign vld_p0 = (hcnt < H_ACT) && (vcnt < V_ACT);
  assign hs_p0  = !((hcnt >= H_SS) && (hcnt <= H_SE));
  assign vs_p0  = !((vcnt >= V_SS) && (vcnt <= V_SE));
  assign fs_p0  = (hcnt == '0) && (vcnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (h_wrap) begin
      hcnt <= '0;
      vcnt <= v_wrap ? '0 : vcnt + 10'd1;
    end else begin
      hcnt <= hcnt + 10'd1;
    end
  end

  // Base advances after every second line so each image row is shown twice.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_base   <= '0;
      en_latched <= 1'b0;
    end else if (h_wrap) begin
      if (v_wrap) begin
        row_base   <= '0;
        en_latched <= video_en;
      end else if (vcnt[0] && (vcnt < V_ACT) && (vcnt < V_IMG)) begin
        row_base <= row_base + ROW_STEP;
      end
    end
  end

  // ---- stage 1: BRAM address register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bram_addr <= '0;
      vld_p1    <= 1'b0;
      hs_p1     <= 1'b1;
      vs_p1     <= 1'b1;
      fs_p1     <= 1'b0;
    end else begin
      bram_addr <= vld_p0 ? row_base + {8'b0, hcnt[9:1]} : '0;
      vld_p1    <= vld_p0;
      hs_p1     <= hs_p0;
      vs_p1     <= vs_p0;
      fs_p1     <= fs_p0;
    end
  end

  // ---- stage 2: BRAM read latency ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2 <= 1'b0;
      hs_p2  <= 1'b1;
      vs_p2  <= 1'b1;
      fs_p2  <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
      hs_p2  <= hs_p1;
      vs_p2  <= vs_p1;
      fs_p2  <= fs_p1;
    end
  end

  // ---- stage 3: output register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync                 <= 1'b1;
      vsync                 <= 1'b1;
      de                    <= 1'b0;
      frame_start           <= 1'b0;
      {vga_r, vga_g, vga_b} <= '0;
    end else begin
      hsync                 <= hs_p2;
      vsync                 <= vs_p2;
      de                    <= vld_p2;
      frame_start           <= fs_p2;
      {vga_r, vga_g, vga_b} <= gate_pix(bram_data, vld_p2 && en_latched);
    end
  end

endmodule

// File: tb/tb_vga_image_reader.sv
// Bench for vga_image_reader using a reduced raster so several whole frames fit in a short run.
// Expected outputs come from a positional model: cycles since reset -> (frame, x, y).
module tb_vga_image_reader;

  localparam int HA = 16, HF = 2, HS = 4, HB = 2;
  localparam int VA = 8, VF = 1, VS = 2, VB = 1;
  localparam int IW = 8, IH = 4;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int MEM_N = IW * IH;
  localparam int LOG_N = 8192;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        video_en = 1'b0;
  logic [16:0] bram_addr;
  logic [11:0] bram_data = '0;
  logic        hsync, vsync, de, frame_start;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic [15:0] obs;

  logic [11:0] mem [MEM_N];
  logic        ven_log [LOG_N];
  int          n = 0;
  int          vectors = 0;
  int          errors = 0;

  vga_image_reader #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .IMG_W(IW), .IMG_H(IH)
  ) dut (
    .clk(clk), .rst(rst), .video_en(video_en),
    .bram_addr(bram_addr), .bram_data(bram_data),
    .hsync(hsync), .vsync(vsync),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .de(de), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  assign obs = {hsync, vsync, de, frame_start, vga_r, vga_g, vga_b};

  // Synchronous BRAM with one clock of read latency.
  always @(posedge clk)
    bram_data <= (bram_addr < 17'(MEM_N)) ? mem[bram_addr] : 12'hBAD;

  // n = clock edges since reset release; video_en is logged per raster position.
  always @(posedge clk or posedge rst) begin
    if (rst) n <= 0;
    else begin
      if (n < LOG_N) ven_log[n] <= video_en;
      n <= n + 1;
    end
  end

  // Output after edge n shows raster position n-3 of the free-running frame sequence.
  function automatic logic [15:0] exp_out(input int k);
    int i, f, p, h, v;
    logic act, en;
    logic [11:0] pix;
    if (k < 3) return 16'hC000;
    i = k - 3;
    f = i / FRAME;
    p = i % FRAME;
    h = p % HT;
    v = p / HT;
    act = (h < HA) && (v < VA);
    en = (f == 0) ? 1'b0 : ven_log[f * FRAME - 1];
    pix = (act && en) ? mem[(v / 2) * IW + h / 2] : 12'h000;
    return {!((h >= HA + HF) && (h < HA + HF + HS)),
            !((v >= VA + VF) && (v < VA + VF + VS)),
            act, (h == 0) && (v == 0), pix};
  endfunction

  function automatic logic [16:0] exp_addr(input int k);
    int p, h, v;
    if (k < 1) return 17'd0;
    p = (k - 1) % FRAME;
    h = p % HT;
    v = p / HT;
    if ((h < HA) && (v < VA)) return 17'((v / 2) * IW + h / 2);
    return 17'd0;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    video_en = 1'b1;
    repeat (3) @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors++;
      if (obs !== 16'hC000) begin
        errors++;
        $display("FAIL reset_out got %h want %h", obs, 16'hC000);
      end
      vectors++;
      if (bram_addr !== 17'd0) begin
        errors++;
        $display("FAIL reset_addr got %0d want 0", bram_addr);
      end
    end
  endtask

  task automatic test_stream();
    logic [15:0] e;
    logic [16:0] a;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4 * FRAME + 5; c++) begin
      @(negedge clk);
      e = exp_out(n);
      a = exp_addr(n);
      vectors++;
      if (obs !== e) begin
        errors++;
        $display("FAIL stream_out n=%0d got %h want %h", n, obs, e);
      end
      vectors++;
      if (bram_addr !== a) begin
        errors++;
        $display("FAIL stream_addr n=%0d got %0d want %0d", n, bram_addr, a);
      end
      if ($urandom_range(0, 199) == 0) video_en = ~video_en;
    end
  endtask

  task automatic test_enable_latch();
    logic [15:0] e;
    int guard;
    video_en = 1'b1;
    guard = 0;
    while ((n % FRAME) != 0 && guard < 2 * FRAME) begin
      @(negedge clk);
      guard++;
    end
    vectors++;
    if ((n % FRAME) != 0) begin
      errors++;
      $display("FAIL latch_align n=%0d got %0d want 0", n, n % FRAME);
    end
    for (int c = 0; c < 3 * FRAME + 5; c++) begin
      @(negedge clk);
      if (c == FRAME + 5 * HT) video_en = 1'b0;
      e = exp_out(n);
      vectors++;
      if (obs !== e) begin
        errors++;
        $display("FAIL latch_out n=%0d got %h want %h", n, obs, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] e;
    logic [16:0] a;
    int run;
    video_en = 1'b1;
    run = FRAME + $urandom_range(FRAME / 4, 3 * FRAME / 4);
    for (int c = 0; c < run; c++) begin
      @(negedge clk);
      e = exp_out(n);
      vectors++;
      if (obs !== e) begin
        errors++;
        $display("FAIL premid_out n=%0d got %h want %h", n, obs, e);
      end
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (obs !== 16'hC000 || bram_addr !== 17'd0) begin
      errors++;
      $display("FAIL async_rst got %h/%0d want c000/0", obs, bram_addr);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      vectors++;
      if (obs !== 16'hC000 || bram_addr !== 17'd0) begin
        errors++;
        $display("FAIL held_rst got %h/%0d want c000/0", obs, bram_addr);
      end
    end
    rst = 1'b0;
    for (int c = 0; c < 2 * FRAME + 10; c++) begin
      @(negedge clk);
      if (c == FRAME / 2) video_en = ($urandom_range(0, 1) == 1);
      e = exp_out(n);
      a = exp_addr(n);
      vectors++;
      if (obs !== e) begin
        errors++;
        $display("FAIL postmid_out n=%0d got %h want %h", n, obs, e);
      end
      vectors++;
      if (bram_addr !== a) begin
        errors++;
        $display("FAIL postmid_addr n=%0d got %0d want %0d", n, bram_addr, a);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < MEM_N; k++) mem[k] = 12'($urandom);
    for (int k = 0; k < LOG_N; k++) ven_log[k] = 1'b0;
    test_reset();
    test_stream();
    test_enable_latch();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/vga_image_reader.md
VGA_IMAGE_READER -- requirements
Module: vga_image_reader

Interface
REQ-001 Parameters: H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48; V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33; IMG_W 320; IMG_H 240.
REQ-002 clk  input  1  pixel clock (25.175 MHz); sole clock domain.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 video_en  input  1  1 = show image, 0 = black frame; sampled only at frame boundary.
REQ-005 bram_addr  output  17  read address to image BRAM, row-major, 0..76799.
REQ-006 bram_data  input  12  BRAM read data {R[3:0],G[3:0],B[3:0]}, valid one clk after bram_addr is sampled.
REQ-007 hsync  output  1  horizontal sync, active-low.
REQ-008 vsync  output  1  vertical sync, active-low.
REQ-009 vga_r, vga_g, vga_b  output  4 each  pixel colour.
REQ-010 de  output  1  display-enable, high during active pixels on the output.
REQ-011 frame_start  output  1  one-clk pulse coincident with output pixel (0,0).

Function
REQ-012 hcnt counts 0..799 and wraps to 0; vcnt increments when hcnt wraps, counts 0..524, wraps to 0.
REQ-013 Stage-0 active = (hcnt < 640) && (vcnt < 480); stage-0 hsync_n = !(656 <= hcnt <= 751); stage-0 vsync_n = !(490 <= vcnt <= 491).
REQ-014 2x upscale: output pixel (x,y) shows image pixel (x>>1, y>>1).
REQ-015 bram_addr registered: row_base + (hcnt>>1) when stage-0 active, else 0; no multiplier.
REQ-016 row_base resets to 0; adds 320 at hcnt==799 on odd vcnt < 480; clears to 0 at vcnt==524, hcnt==799.
REQ-017 Fixed pipeline depth 3: hsync, vsync, de, rgb, frame_start on output reflect stage-0 counter state exactly 3 clks earlier (addr reg, BRAM reg, output reg).
REQ-018 Output rgb = bram_data when delayed active && en_latched, else 12'h000.
REQ-019 en_latched loads video_en at hcnt==799, vcnt==524 only; a video_en change mid-frame has no effect until next frame.
REQ-020 de = delayed active regardless of en_latched.
REQ-021 frame_start high for one clk when delayed (hcnt,vcnt)==(0,0); period 420000 clks.
REQ-022 bram_addr never exceeds 76799; maximum value 76799 issued at stage-0 (639,479).
REQ-023 All outputs registered; no combinational path from bram_data to outputs.

Reset
REQ-024 rst asserted: hcnt=0, vcnt=0, row_base=0, bram_addr=0, en_latched=0, pipeline active/frame_start bits=0, hsync=1, vsync=1, rgb=0, de=0, frame_start=0, immediately (asynchronous).
REQ-025 After rst deasserts, counting starts at the next clk edge from (0,0); first frame_start at the 3rd clk edge after the first edge with rst low; first frame is black (en_latched=0) irrespective of video_en.
REQ-026 rst asserted mid-frame: all state returns to REQ-024 values; no partial-line or glitched sync pulse after release beyond normal timing.

Verification
REQ-027 Timing: run 2 frames -> hsync low 96 clks every 800, vsync low 2 lines (1600 clks) every 525 lines, de high 640 clks/line for 480 lines, frame_start period 420000.
REQ-028 Address: stage-0 (0,0),(1,0),(2,0),(639,0),(0,1),(0,2),(639,479) -> bram_addr 0,0,1,319,0,320,76799; blanking -> 0.
REQ-029 Data/latency: BRAM model bram[n]=n[11:0], video_en=1 from reset -> frame 2 output (x,y) = ((y>>1)*320+(x>>1))[11:0], aligned with de; frame 1 all black.
REQ-030 Enable latch: toggle video_en to 0 at line 100 of a visible frame -> that frame unchanged, next frame rgb=0 for all pixels, de/sync unaffected.
REQ-031 Reset mid-frame: assert rst at (hcnt,vcnt)=(300,200) for 5 clks -> outputs at reset values during rst; after release first frame_start exactly 3 clks after first active edge, timing as REQ-027.
REQ-032 Wrap: observe hcnt 799->0 with vcnt 524->0 -> row_base=0, en_latched updated, no extra hsync/vsync pulse.
